ram2_arbiter: RTL and testbench
===============================

# ram2_arbiter

Two-port round-robin arbiter and sequencer for the single-port 32x32 RAM with a bidirectional data bus. It accepts independent read/write requests from two requesters and serialises them into one RAM access at a time. It drives the RAM's `ena`/`wena`/`addr` pins and owns the tri-state direction of the shared `data` bus. It sits between the RAM and the two datapath clients, which never touch the RAM pins directly.

## Interface
- `ADDR_W`, default 5: RAM address width.
- `DATA_W`, default 32: RAM word width.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0` / `req1`  in  1  request from port 0 / port 1; held high until ack.
- `we0` / `we1`  in  1  1 = write, 0 = read; stable while req high.
- `addr0` / `addr1`  in  ADDR_W  word address; stable while req high.
- `wdata0` / `wdata1`  in  DATA_W  write data; stable while req high.
- `rdata0` / `rdata1`  out  DATA_W  read result; valid when the matching ack is high, then held.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in any state other than IDLE.
- `ram_ena`  out  1  RAM enable.
- `ram_wena`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_data`  inout  DATA_W  shared RAM data bus. Driven only when `ram_ena && ram_wena`; otherwise `'z`.

## Operation
- FSM states: IDLE, ACCESS, DONE. All outputs are registered except the `ram_data` tri-state enable, which is decoded from state.
- IDLE: on a clock edge where `req0 | req1`:
  - Pick the winner.
  - Latch its `we`, `addr` and `wdata` into internal registers and record `grant`.
  - Move to ACCESS.
  - With no request, stay in IDLE.
- Arbitration:
  - Only one request pending: that port wins.
  - Both pending: the port not granted last wins.
  - The last-grant pointer resets to port 1, so port 0 wins the first tie after reset.
- ACCESS, exactly one cycle:
  - `ram_ena=1`, `ram_wena=we_r`, `ram_addr=addr_r`.
  - Write: `ram_data` is driven with `wdata_r`, and the RAM stores it on the edge that ends ACCESS.
  - Read: `ram_data` is released and `rdata[grant]` captures it on the edge that ends ACCESS.
  - Move to DONE.
- DONE, one cycle:
  - `ack[grant]=1`, `ram_ena=0`, `ram_wena=0`, bus released.
  - This cycle is also the mandatory bus-turnaround cycle.
  - Move to IDLE and update the last-grant pointer.
- Requester rule: deassert `req` on the edge after seeing `ack`. Keeping `req` high starts a new transaction from the following IDLE. This transaction is subject to arbitration and uses whatever `we`/`addr`/`wdata` are present then.
- Requests arriving in ACCESS or DONE wait; they are never lost or dropped.
- The `rdata` of the non-granted port is never modified.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - state IDLE, `busy=0`, `ram_ena=0`, `ram_wena=0`, `ram_addr=0`.
  - `ack0=ack1=0`, `rdata0=rdata1=0`.
  - `ram_data='z`, last-grant pointer = 1.
- Latency: a req sampled high in IDLE at edge N gives ACCESS in cycle N..N+1 and `ack` high in cycle N+1..N+2. That is the 2nd cycle after the sampling edge.
- Throughput: one access per 3 cycles, including the turnaround cycle.
- Reset asserted during ACCESS: `ram_ena` and the bus drive drop immediately. The write is aborted and no ack is issued.
- Reset asserted during DONE: the ack pulse is truncated to 0.
- Address is full ADDR_W range; there is no wrap or bounds logic beyond natural width.
- The controller and RAM never drive `ram_data` in the same cycle. This is guaranteed by the bus being released in IDLE and DONE.

## Configuration
- `RAM2_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. Port 0 always wins a simultaneous request, and the last-grant pointer is removed.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- Single write: reset; `req0=1`, `we0=1`, `addr0=5`, `wdata0=32'hDEADBEEF`. Requires `ram_ena=ram_wena=1` and `ram_data=32'hDEADBEEF` for exactly one cycle, then `ack0` high one cycle later, 2 cycles after sampling.
- Read-back: after the write, port 1 reads addr 5. Requires `rdata1=32'hDEADBEEF` when `ack1` is high, `ram_data` not driven by the arbiter, and `rdata0` unchanged.
- Tie fairness: `req0` and `req1` held high for 4 transactions. Requires grant order 0,1,0,1 and acks 3 cycles apart. With `RAM2_ARB_FIXED_PRIO_EN` the grant order is 0,0,0,0 while `req0` is held.
- Bus turnaround: write followed immediately by a read to another address. Requires a cycle with `ram_ena=0` and `ram_data` all z between the two ACCESS cycles.
- Reset mid-write: assert `rst_n=0` during ACCESS of a write to addr 7 with data `32'h1234`. Requires `ram_ena` low immediately and all outputs at reset values, and a later read of addr 7 returning its previous content (0).
- Idle hold: no requests for 10 cycles. Requires `busy=0`, `ram_ena=0`, and no ack pulses.

Source files
------------

// File: rtl/ram2_arbiter.sv
// Round-robin (or fixed-priority with RAM2_ARB_FIXED_PRIO_EN) arbiter/sequencer for a single-port RAM.
// Latency: ack two cycles after req sampled in IDLE; requests stall (never drop) while busy.
module ram2_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              busy,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nx;
  logic              win;
  logic              grant;
  logic              we_r;
  logic [DATA_W-1:0] wdata_r;

`ifndef RAM2_ARB_FIXED_PRIO_EN
  logic last_grant;
`endif

  // Only the controller's write cycle drives the bus; IDLE and DONE leave it released.
  assign ram_data = (ram_ena && ram_wena) ? wdata_r : {DATA_W{1'bz}};

  always_comb begin
    win = 1'b0;
`ifdef RAM2_ARB_FIXED_PRIO_EN
    win = !req0;
`else
    if (req0 && req1) win = !last_grant;
    else              win = !req0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req0 || req1) state_nx = ACCESS;
      ACCESS:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      ram_ena  <= 1'b0;
      ram_wena <= 1'b0;
      ram_addr <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      grant    <= 1'b0;
      we_r     <= 1'b0;
      wdata_r  <= '0;
`ifndef RAM2_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      busy <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant    <= win;
            we_r     <= win ? we1 : we0;
            wdata_r  <= win ? wdata1 : wdata0;
            ram_ena  <= 1'b1;
            ram_wena <= win ? we1 : we0;
            ram_addr <= win ? addr1 : addr0;
          end
        end
        ACCESS: begin
          ram_ena  <= 1'b0;
          ram_wena <= 1'b0;
          if (!we_r) begin
            if (grant) rdata1 <= ram_data;
            else       rdata0 <= ram_data;
          end
          if (grant) ack1 <= 1'b1;
          else       ack0 <= 1'b1;
        end
        DONE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
`ifndef RAM2_ARB_FIXED_PRIO_EN
          last_grant <= grant;
`endif
        end
        default: begin
          ram_ena  <= 1'b0;
          ram_wena <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram2_arbiter.sv
// Directed bench for ram2_arbiter with a behavioural async-read RAM on the shared bus.
// A pulldown makes a released bus read as zero.
module tb_ram2_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              ack0, ack1, busy, ram_ena, ram_wena;
  logic [ADDR_W-1:0] ram_addr;
  wire  [DATA_W-1:0] ram_data;

  logic [DATA_W-1:0] mem [0:31];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram2_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdata0(rdata0), .rdata1(rdata1), .ack0(ack0), .ack1(ack1), .busy(busy),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  for (genvar b = 0; b < DATA_W; b++) begin : g_pd
    pulldown (ram_data[b]);
  end

  assign ram_data = (ram_ena && !ram_wena) ? mem[ram_addr] : {DATA_W{1'bz}};

  always @(posedge clk) begin
    if (ram_ena && ram_wena) mem[ram_addr] <= ram_data;
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (ram_ena !== 1'b0) begin n_fail++; $display("FAIL reset_ena got %b exp 0", ram_ena); end
    n_checks++; if (ram_wena !== 1'b0) begin n_fail++; $display("FAIL reset_wena got %b exp 0", ram_wena); end
    n_checks++; if (ram_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", ram_addr); end
    n_checks++; if ({ack0, ack1} !== 2'b00) begin n_fail++; $display("FAIL reset_ack got %b exp 00", {ack0, ack1}); end
    n_checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h/%h exp 0/0", rdata0, rdata1); end
    n_checks++; if (ram_data !== 32'h0) begin n_fail++; $display("FAIL reset_bus got %h exp released", ram_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++; if ({ram_ena, ram_wena} !== 2'b11) begin n_fail++; $display("FAIL wr_access_en got %b exp 11", {ram_ena, ram_wena}); end
    n_checks++; if (ram_addr !== 5'd5) begin n_fail++; $display("FAIL wr_access_addr got %h exp 05", ram_addr); end
    n_checks++; if (ram_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_access_bus got %h exp deadbeef", ram_data); end
    n_checks++; if (ack0 !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL wr_access_ack_busy got %b%b exp 01", ack0, busy); end
    @(negedge clk);
    n_checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin n_fail++; $display("FAIL wr_done_ack got %b%b exp 10", ack0, ack1); end
    n_checks++; if (ram_ena !== 1'b0 || ram_data !== 32'h0) begin n_fail++; $display("FAIL wr_done_bus got ena %b bus %h exp 0/released", ram_ena, ram_data); end
    req0 = 1'b0;
    @(negedge clk);
    n_checks++; if (ack0 !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle got ack %b busy %b exp 0/0", ack0, busy); end
    n_checks++; if (mem[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_stored got %h exp deadbeef", mem[5]); end
  endtask

  task automatic test_read_back();
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd5;
    @(negedge clk);
    n_checks++; if ({ram_ena, ram_wena} !== 2'b10) begin n_fail++; $display("FAIL rd_access_en got %b exp 10", {ram_ena, ram_wena}); end
    n_checks++; if (ram_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_access_bus got %h exp deadbeef", ram_data); end
    @(negedge clk);
    n_checks++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin n_fail++; $display("FAIL rd_done_ack got %b%b exp 01", ack0, ack1); end
    n_checks++; if (rdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata1 got %h exp deadbeef", rdata1); end
    n_checks++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL rd_rdata0_kept got %h exp 0", rdata0); end
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie_fairness();
    logic e0, e1;
    we0 = 1'b0; addr0 = 5'd5; we1 = 1'b0; addr1 = 5'd0;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
`ifdef RAM2_ARB_FIXED_PRIO_EN
      e0 = (i == 1 || i == 4 || i == 7 || i == 10);
      e1 = 1'b0;
`else
      e0 = (i == 1 || i == 7);
      e1 = (i == 4 || i == 10);
`endif
      n_checks++; if (ack0 !== e0 || ack1 !== e1) begin n_fail++; $display("FAIL tie_ack cyc %0d got %b%b exp %b%b", i, ack0, ack1, e0, e1); end
      if (i == 1) begin
        n_checks++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL tie_rdata0 got %h exp deadbeef", rdata0); end
      end
      if (i == 10) begin req0 = 1'b0; req1 = 1'b0; end
    end
  endtask

  task automatic test_back_to_back();
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd9; wdata0 = 32'h000055AA;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd5;
    @(negedge clk);
    n_checks++; if ({ram_ena, ram_wena} !== 2'b11 || ram_data !== 32'h000055AA) begin n_fail++; $display("FAIL b2b_wr got en %b bus %h exp 11/55aa", {ram_ena, ram_wena}, ram_data); end
    @(negedge clk);
    n_checks++; if (ack0 !== 1'b1 || ram_ena !== 1'b0 || ram_data !== 32'h0) begin n_fail++; $display("FAIL b2b_turn got ack0 %b ena %b bus %h exp 1/0/released", ack0, ram_ena, ram_data); end
    req0 = 1'b0;
    @(negedge clk);
    n_checks++; if (ram_ena !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got ena %b exp 0", ram_ena); end
    @(negedge clk);
    n_checks++; if ({ram_ena, ram_wena} !== 2'b10 || ram_addr !== 5'd5) begin n_fail++; $display("FAIL b2b_rd got en %b addr %h exp 10/05", {ram_ena, ram_wena}, ram_addr); end
    @(negedge clk);
    n_checks++; if (ack1 !== 1'b1 || rdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_rd_done got ack1 %b rdata1 %h exp 1/deadbeef", ack1, rdata1); end
    n_checks++; if (mem[9] !== 32'h000055AA) begin n_fail++; $display("FAIL b2b_stored got %h exp 55aa", mem[9]); end
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd7; wdata0 = 32'h00001234;
    @(negedge clk);
    n_checks++; if (ram_ena !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got ena %b exp 1", ram_ena); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({ram_ena, ram_wena, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_ctl got %b exp 000", {ram_ena, ram_wena, busy}); end
    n_checks++; if (ram_data !== 32'h0 || ram_addr !== 5'd0) begin n_fail++; $display("FAIL rst_mid_bus got bus %h addr %h exp released/0", ram_data, ram_addr); end
    n_checks++; if ({ack0, ack1} !== 2'b00 || rdata0 !== 32'h0 || rdata1 !== 32'h0) begin n_fail++; $display("FAIL rst_mid_out got ack %b rdata %h/%h exp 00 0/0", {ack0, ack1}, rdata0, rdata1); end
    req0 = 1'b0;
    @(negedge clk);
    n_checks++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_noack got %b exp 0", ack0); end
    rst_n = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd7;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (ack1 !== 1'b1 || rdata1 !== 32'h0) begin n_fail++; $display("FAIL rst_mid_read got ack1 %b rdata1 %h exp 1/0", ack1, rdata1); end
    n_checks++; if (mem[7] !== 32'h0) begin n_fail++; $display("FAIL rst_mid_mem got %h exp 0", mem[7]); end
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if ({busy, ram_ena, ack0, ack1} !== 4'b0000) begin n_fail++; $display("FAIL idle cyc %0d got busy/ena/ack %b exp 0000", i, {busy, ram_ena, ack0, ack1}); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_tie_fairness();
    test_back_to_back();
    test_reset_mid_write();
    test_idle_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
